// File: rtl/race_ctrl_pkg.sv
// Shared types and constants for the drag-race sequencing controller.
// Imported by the interface, the player dynamics block and the top FSM.
package race_pkg;

  localparam int POS_W  = 11;
  localparam int SPD_W  = 4;
  localparam int SUM_W  = 12;
  localparam int CNT_W  = 16;
  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISH    = 2'd3
  } state_t;

  localparam int WIN_P1 = 0;
  localparam int WIN_P2 = 1;
  localparam int FS_P1  = 0;
  localparam int FS_P2  = 1;

  // Reload value for a down-counter that must fire every n ticks.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/race_ctrl_if.sv
// Keyboard/frame pulses into the race controller and its registered
// outputs toward the drawing pipeline.
interface race_ctrl_if;

  logic                         frame_tick;
  logic                         start_key;
  logic                         p1_key;
  logic                         p2_key;
  logic [1:0]                   state;
  logic [2:0]                   lights;
  logic [race_pkg::POS_W-1:0]   p1_pos;
  logic [race_pkg::POS_W-1:0]   p2_pos;
  logic [race_pkg::SPD_W-1:0]   p1_speed;
  logic [race_pkg::SPD_W-1:0]   p2_speed;
  logic [1:0]                   winner;
  logic [1:0]                   false_start;
  logic [race_pkg::TIME_W-1:0]  race_time;

  modport master (
    output frame_tick, start_key, p1_key, p2_key,
    input  state, lights, p1_pos, p2_pos, p1_speed, p2_speed,
    input  winner, false_start, race_time
  );

  modport slave (
    input  frame_tick, start_key, p1_key, p2_key,
    output state, lights, p1_pos, p2_pos, p1_speed, p2_speed,
    output winner, false_start, race_time
  );

endinterface

// File: rtl/race_ctrl_player_dyn.sv
// Per-player speed and track position: saturating speed with press/decay
// arbitration, and a frame-rate position accumulator clamped at the finish.
module player_dyn
  import race_pkg::*;
#(
  parameter int TRACK_LEN = 1000,
  parameter int MAX_SPEED = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_press,
  input  logic             i_tick,
  input  logic             i_decay,
  output logic [POS_W-1:0] o_pos,
  output logic [SPD_W-1:0] o_speed,
  output logic             o_finish_hit
);

  logic [POS_W-1:0] r_pos;
  logic [SPD_W-1:0] r_speed;
  logic [SUM_W-1:0] w_sum;
  logic             w_press;
  logic             w_decay;
  logic             w_tick;

  assign w_press = i_en & i_press;
  assign w_decay = i_en & i_decay;
  assign w_tick  = i_en & i_tick;

  // Position advances with the speed held before any same-cycle press.
  assign w_sum        = SUM_W'(r_pos) + SUM_W'(r_speed);
  assign o_finish_hit = w_tick & (w_sum >= SUM_W'(TRACK_LEN));

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_pos   <= '0;
      r_speed <= '0;
    end else begin
      if (w_tick)
        r_pos <= o_finish_hit ? POS_W'(TRACK_LEN) : w_sum[POS_W-1:0];
      if (w_press && !w_decay) begin
        if (r_speed != SPD_W'(MAX_SPEED))
          r_speed <= r_speed + 1'b1;
      end else if (w_decay && !w_press && r_speed != '0) begin
        r_speed <= r_speed - 1'b1;
      end
    end
  end

  assign o_pos   = r_pos;
  assign o_speed = r_speed;

endmodule

// File: rtl/race_ctrl.sv
// Race lifecycle FSM: countdown lights, false starts, race and winner.
// Optional race timer is built when RACE_CTRL_TIMER_EN is defined.
//
// state        | meaning
// ST_IDLE      | all outputs cleared, waiting for start_key
// ST_COUNTDOWN | lamps step 001/011/111, any throttle is a false start
// ST_RACE      | players accelerate, positions integrate per frame
// ST_FINISH    | everything frozen until start_key
module race_ctrl
  import race_pkg::*;
#(
  parameter int LIGHT_FRAMES = 60,
  parameter int TRACK_LEN    = 1000,
  parameter int MAX_SPEED    = 15,
  parameter int DECAY_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  race_ctrl_if.slave  bus
);

  state_t           r_state;
  logic [2:0]       r_lights;
  logic [1:0]       r_winner;
  logic [1:0]       r_false_start;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [1:0]       r_light_cnt;
  logic [CNT_W-1:0] r_decay_cnt;

  logic w_in_race;
  logic w_clear;
  logic w_decay;
  logic w_p1_hit;
  logic w_p2_hit;

  assign w_in_race = (r_state == ST_RACE);
  assign w_decay   = w_in_race & bus.frame_tick & (r_decay_cnt == '0);
  // Clear on the FINISH->IDLE edge too so IDLE shows zeros from its first cycle.
  assign w_clear   = (r_state == ST_IDLE) | ((r_state == ST_FINISH) & bus.start_key);

  player_dyn #(.TRACK_LEN(TRACK_LEN), .MAX_SPEED(MAX_SPEED)) u_p1 (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_en         (w_in_race),
    .i_press      (bus.p1_key),
    .i_tick       (bus.frame_tick),
    .i_decay      (w_decay),
    .o_pos        (bus.p1_pos),
    .o_speed      (bus.p1_speed),
    .o_finish_hit (w_p1_hit)
  );

  player_dyn #(.TRACK_LEN(TRACK_LEN), .MAX_SPEED(MAX_SPEED)) u_p2 (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_en         (w_in_race),
    .i_press      (bus.p2_key),
    .i_tick       (bus.frame_tick),
    .i_decay      (w_decay),
    .o_pos        (bus.p2_pos),
    .o_speed      (bus.p2_speed),
    .o_finish_hit (w_p2_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_lights      <= '0;
      r_winner      <= '0;
      r_false_start <= '0;
      r_frame_cnt   <= '0;
      r_light_cnt   <= '0;
      r_decay_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_key) begin
            r_state     <= ST_COUNTDOWN;
            r_lights    <= 3'b001;
            r_frame_cnt <= cnt_load(LIGHT_FRAMES);
            r_light_cnt <= '0;
          end
        end
        ST_COUNTDOWN: begin
          if (bus.p1_key || bus.p2_key) begin
            r_state              <= ST_FINISH;
            r_false_start[FS_P1] <= bus.p1_key;
            r_false_start[FS_P2] <= bus.p2_key;
            // Opponent wins a single false start; a double one has no winner.
            r_winner[WIN_P1]     <= bus.p2_key & ~bus.p1_key;
            r_winner[WIN_P2]     <= bus.p1_key & ~bus.p2_key;
          end else if (bus.frame_tick) begin
            if (r_frame_cnt == '0) begin
              r_frame_cnt <= cnt_load(LIGHT_FRAMES);
              if (r_light_cnt == 2'd2) begin
                r_state     <= ST_RACE;
                r_lights    <= '0;
                r_decay_cnt <= cnt_load(DECAY_FRAMES);
              end else begin
                r_light_cnt <= r_light_cnt + 1'b1;
                r_lights    <= {r_lights[1:0], 1'b1};
              end
            end else begin
              r_frame_cnt <= r_frame_cnt - 1'b1;
            end
          end
        end
        ST_RACE: begin
          if (bus.frame_tick) begin
            if (r_decay_cnt == '0)
              r_decay_cnt <= cnt_load(DECAY_FRAMES);
            else
              r_decay_cnt <= r_decay_cnt - 1'b1;
            if (w_p1_hit || w_p2_hit) begin
              r_state          <= ST_FINISH;
              r_winner[WIN_P1] <= w_p1_hit;
              r_winner[WIN_P2] <= w_p2_hit;
            end
          end
        end
        ST_FINISH: begin
          if (bus.start_key) begin
            r_state       <= ST_IDLE;
            r_lights      <= '0;
            r_winner      <= '0;
            r_false_start <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RACE_CTRL_TIMER_EN
  logic [TIME_W-1:0] r_race_time;

  always_ff @(posedge clk) begin
    if (!rst || w_clear)
      r_race_time <= '0;
    else if (w_in_race && bus.frame_tick && r_race_time != '1)
      r_race_time <= r_race_time + 1'b1;
  end

  assign bus.race_time = r_race_time;
`else
  assign bus.race_time = '0;
`endif

  assign bus.state       = r_state;
  assign bus.lights      = r_lights;
  assign bus.winner      = r_winner;
  assign bus.false_start = r_false_start;

endmodule

// File: doc/race_ctrl.md
# race_ctrl

Game-sequencing controller for the Drag Racing design, clocked in the 65 MHz pixel domain next to the VGA timing generator. It runs the race lifecycle (idle, start-light countdown, race, finish) and detects false starts. It integrates per-player throttle presses into speed and track position once per video frame and declares the winner. Its registered outputs feed the drawing pipeline and any score logic.

## Interface
- `LIGHT_FRAMES`, 60: frames per countdown light step.
- `TRACK_LEN`, 1000: finish position; legal range 1..2047.
- `MAX_SPEED`, 15: speed ceiling; legal range 1..15.
- `DECAY_FRAMES`, 8: frames between automatic speed decrements.
- `clk` in 1: 65 MHz pixel clock.
- `rst` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: one-cycle pulse once per frame, generated from the vsync edge.
- `start_key` in 1: one-cycle pulse from the keyboard decoder.
- `p1_key`, `p2_key` in 1: one-cycle throttle pulses.
- `state` out 2: current state; IDLE=0, COUNTDOWN=1, RACE=2, FINISH=3.
- `lights` out 3: countdown lamps, thermometer-coded.
- `p1_pos`, `p2_pos` out 11: track positions.
- `p1_speed`, `p2_speed` out 4: current speeds.
- `winner` out 2: bit0 = P1, bit1 = P2; 11 means tie; 00 means none or undecided.
- `false_start` out 2: bit0 = P1, bit1 = P2.
- `race_time` out 16: elapsed race frames.

## Operation
- **IDLE:** all datapath outputs are 0. On `start_key`, go to COUNTDOWN and clear the frame and light counters.
- **COUNTDOWN:** `lights` steps 001 → 011 → 111, advancing every `LIGHT_FRAMES` frame ticks.
  - After 3×`LIGHT_FRAMES` ticks, go to RACE with `lights`=000.
  - A throttle press here is a false start. Set that player's `false_start` bit and go to FINISH with `winner` set to the other player.
  - If both players press in the same cycle, set `false_start`=11 and `winner`=00.
- **RACE:**
  - A key press raises that player's speed by 1, saturating at `MAX_SPEED`.
  - On each `frame_tick`, `pos` ← min(`pos` + speed, `TRACK_LEN`), using the speed held before any same-cycle press.
  - Every `DECAY_FRAMES` ticks, each nonzero speed is decremented. If a press and a decay land on the same cycle, the speed is unchanged.
  - When any position reaches `TRACK_LEN`, go to FINISH. `winner` marks the player(s) that reached it on that tick; both on the same tick gives 11.
- **FINISH:** all outputs are frozen. Presses are ignored. `start_key` returns to IDLE, which clears everything.
- `start_key` is ignored in COUNTDOWN and RACE.
- Internal sums are computed at 12 bits before saturation, so no wrap is possible.

## Timing
- All outputs are registered. Every output resets to 0 and `state` resets to IDLE.
- A state change appears the cycle after the triggering pulse.
- Position and speed updates appear the cycle after `frame_tick`.
- Winner and FINISH appear together, one cycle after the finishing tick.
- Reset asserted at any point, mid-race included, returns to IDLE on the next edge. Pulses coincident with reset are dropped.
- `frame_tick` asserted in the same cycle as `start_key` in IDLE does not count toward the first light.

## Configuration
- Macro: `RACE_CTRL_TIMER_EN`.
- **Defined:** `race_time` counts frame ticks while in RACE and saturates at 0xFFFF. It holds its value in FINISH and clears in IDLE. The finishing tick is counted.
- **Undefined:** `race_time` is tied to 0 and the counter is not built. The port is present in both builds.

## Structure
- Package `race_pkg` holds:
  - the state encoding constants;
  - `POS_W`=11 and `SPD_W`=4;
  - the `winner` and `false_start` bit indices.
- Sub-module `player_dyn` is instantiated once per player. It contains:
  - the saturating speed register with press/decay arbitration;
  - the position accumulator with `TRACK_LEN` clamp and a `finished` flag.
- It also has a `clear` input driven while in IDLE.
- The top FSM owns the frame counter, light counter, decay prescaler and winner logic.

## Test plan
All scenarios use `LIGHT_FRAMES`=2, `TRACK_LEN`=20, `MAX_SPEED`=5, `DECAY_FRAMES`=4.
- **Countdown:** `start_key`, then 6 frame ticks. Expect `lights` 001, 011, 111, then 000 with `state`=RACE after the 6th tick.
- **P1 false start:** `p1_key` during 011. Expect the next cycle to show FINISH, `false_start`=01, `winner`=10. A later `start_key` returns to IDLE with all outputs 0.
- **Saturation and decay:** in RACE, 7 `p1_key` pulses then one tick. Expect `p1_speed`=5 and `p1_pos`=5. After 4 ticks, speed is 4 and position is 20, clamped; FINISH with `winner`=01.
- **Tie:** both players at speed 5 from the same cycle. Expect both to reach 20 on the same tick, `winner`=11.
- **Coincident events:** press coinciding with a decay tick leaves speed unchanged. `rst` low mid-race gives IDLE with zeroed outputs after one edge.
- **Timer:** with `RACE_CTRL_TIMER_EN`, the P1 single-player win above gives `race_time`=4. Without the macro it reads 0.
